mem_char_sequencer: RTL

Upstream sequencer for the modified Enigma machine datapath. It accepts an ASCII character stream over a valid/ready handshake and presents each character plus the current 2-bit rotor `setting` to the combinational MEM core. It captures MEM's result in a registered output stage and advances the setting after a programmable number of enciphered letters, rotor-style. Non-letters bypass MEM and do not step.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_step_ctr.sv | 50 +++++
 rtl/mem_char_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the MEM character sequencer: letter bounds, setting width and the
// sequencer state encoding.
package mem_pkg;

  localparam logic [7:0] LETTER_A = 8'h41;
  localparam logic [7:0] LETTER_Z = 8'h5A;

  localparam int unsigned SETTING_W = 2;

  localparam logic [0:0] ST_UNKEYED = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;

  // Only uppercase ASCII is enciphered; everything else bypasses MEM.
  function automatic logic is_letter(input logic [7:0] ch);
    return (ch >= LETTER_A) && (ch <= LETTER_Z);
  endfunction

endpackage

// File: rtl/mem_step_ctr.sv
// Rotor-style setting register: advances the 2-bit setting once every STEP_PERIOD
// enciphered letters, and restarts from a loaded key.
module mem_step_ctr
  import mem_pkg::*;
#(
  parameter int unsigned STEP_PERIOD = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [SETTING_W-1:0] load_setting_i,
  input  logic                 step_en_i,
  output logic [SETTING_W-1:0] setting_o
);

  localparam logic [7:0] LastCnt = 8'(STEP_PERIOD - 1);

  logic [7:0]           step_cnt_q, step_cnt_d;
  logic [SETTING_W-1:0] setting_q, setting_d;

  always_comb begin
    step_cnt_d = step_cnt_q;
    setting_d  = setting_q;
    if (load_i) begin
      step_cnt_d = '0;
      setting_d  = load_setting_i;
    end else if (step_en_i) begin
      if (step_cnt_q == LastCnt) begin
        step_cnt_d = '0;
        // Two-bit add wraps 3 -> 0 on its own.
        setting_d  = setting_q + 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      setting_q  <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      setting_q  <= setting_d;
    end
  end

  assign setting_o = setting_q;

endmodule

// File: rtl/mem_char_sequencer.sv
// Feeds an ASCII stream through the combinational MEM core with the current rotor setting
// and registers the result behind a valid/ready output stage.
module mem_char_sequencer
  import mem_pkg::*;
#(
  parameter int unsigned STEP_PERIOD = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  input  logic [SETTING_W-1:0] cfg_setting,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8:1]           in_char,
  output logic [8:1]           mem_in,
  output logic [SETTING_W-1:0] mem_setting,
  input  logic [8:1]           mem_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8:1]           out_char,
  output logic [15:0]          letter_count
);

  logic [0:0]  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [8:1]  out_char_q, out_char_d;
  logic [15:0] letter_count_q, letter_count_d;

  logic accept;
  logic letter;
  logic step_en;

  // Key load takes priority over any input in the same cycle.
  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready) && !cfg_valid;
  assign accept   = in_valid && in_ready;
  assign letter   = is_letter(in_char);
  assign step_en  = accept && letter;

  assign mem_in = in_char;

  mem_step_ctr #(
    .STEP_PERIOD(STEP_PERIOD)
  ) u_step_ctr (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (cfg_valid),
    .load_setting_i(cfg_setting),
    .step_en_i     (step_en),
    .setting_o     (mem_setting)
  );

  always_comb begin
    state_d = state_q;
    if (cfg_valid) begin
      state_d = ST_RUN;
    end
  end

  // A pending output survives a key load: it was enciphered under the old key.
  always_comb begin
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_char_d  = letter ? mem_out : in_char;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    letter_count_d = letter_count_q;
    if (cfg_valid) begin
      letter_count_d = '0;
    end else if (step_en) begin
      letter_count_d = letter_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_UNKEYED;
      out_valid_q    <= 1'b0;
      out_char_q     <= '0;
      letter_count_q <= '0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_char_q     <= out_char_d;
      letter_count_q <= letter_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_char     = out_char_q;
  assign letter_count = letter_count_q;

endmodule
